// File: rtl/apb_rr_arbiter_master_if.sv
// APB bus bundle shared by the round-robin APB master and the slave it drives.
interface apb_rr_arbiter_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] PADDR;
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_rr_arbiter_master.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing, PREADY timeout,
// per-requester done pulse with held read data and error status.
module apb_rr_arbiter_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   req0,
    input  logic                   wr0,
    input  logic [ADDR_W-1:0]      addr0,
    input  logic [DATA_W-1:0]      wdata0,
    output logic                   done0,
    output logic [DATA_W-1:0]      rdata0,
    output logic                   err0,
    input  logic                   req1,
    input  logic                   wr1,
    input  logic [ADDR_W-1:0]      addr1,
    input  logic [DATA_W-1:0]      wdata1,
    output logic                   done1,
    output logic [DATA_W-1:0]      rdata1,
    output logic                   err1,
    apb_rr_arbiter_master_if.master apb
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              ptr_r, ptr_nxt_s;
    logic              owner_r, owner_nxt_s;
    logic              psel_r, psel_nxt_s;
    logic              penable_r, penable_nxt_s;
    logic              pwrite_r, pwrite_nxt_s;
    logic [ADDR_W-1:0] paddr_r, paddr_nxt_s;
    logic [DATA_W-1:0] pwdata_r, pwdata_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              done0_r, done0_nxt_s;
    logic              done1_r, done1_nxt_s;
    logic [DATA_W-1:0] rdata0_r, rdata0_nxt_s;
    logic [DATA_W-1:0] rdata1_r, rdata1_nxt_s;
    logic              err0_r, err0_nxt_s;
    logic              err1_r, err1_nxt_s;

    logic              elig0_s, elig1_s, grant1_s;
    logic              finish_s, fin_err_s, fin_rd_s;

    // A requester that just completed sits out the following IDLE cycle so a
    // still-high req is not mistaken for a new command.
    assign elig0_s  = req0 & ~done0_r;
    assign elig1_s  = req1 & ~done1_r;
    // ptr_r names the port preferred on contention.
    assign grant1_s = elig1_s & (~elig0_s | ptr_r);

    // Next-state, command capture and completion logic.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        owner_nxt_s   = owner_r;
        psel_nxt_s    = 1'b0;
        penable_nxt_s = 1'b0;
        pwrite_nxt_s  = pwrite_r;
        paddr_nxt_s   = paddr_r;
        pwdata_nxt_s  = pwdata_r;
        cnt_nxt_s     = cnt_r;
        done0_nxt_s   = 1'b0;
        done1_nxt_s   = 1'b0;
        rdata0_nxt_s  = rdata0_r;
        rdata1_nxt_s  = rdata1_r;
        err0_nxt_s    = err0_r;
        err1_nxt_s    = err1_r;
        finish_s      = 1'b0;
        fin_err_s     = 1'b0;
        fin_rd_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (elig0_s | elig1_s) begin
                    state_nxt_s  = ST_SETUP;
                    psel_nxt_s   = 1'b1;
                    owner_nxt_s  = grant1_s;
                    ptr_nxt_s    = ~grant1_s;
                    pwrite_nxt_s = grant1_s ? wr1    : wr0;
                    paddr_nxt_s  = grant1_s ? addr1  : addr0;
                    pwdata_nxt_s = grant1_s ? wdata1 : wdata0;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_nxt_s   = ST_ACCESS;
                psel_nxt_s    = 1'b1;
                penable_nxt_s = 1'b1;
            end
            ST_ACCESS: begin
                if (apb.PREADY) begin
                    finish_s  = 1'b1;
                    fin_err_s = apb.PSLVERR;
                    fin_rd_s  = ~pwrite_r;
                end else if (cnt_r == CNT_LAST) begin
                    finish_s  = 1'b1;
                    fin_err_s = 1'b1;
                end else begin
                    psel_nxt_s    = 1'b1;
                    penable_nxt_s = 1'b1;
                    cnt_nxt_s     = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (finish_s) begin
            state_nxt_s = ST_IDLE;
            if (owner_r) begin
                done1_nxt_s  = 1'b1;
                err1_nxt_s   = fin_err_s;
                rdata1_nxt_s = fin_rd_s ? apb.PRDATA : rdata1_r;
            end else begin
                done0_nxt_s  = 1'b1;
                err0_nxt_s   = fin_err_s;
                rdata0_nxt_s = fin_rd_s ? apb.PRDATA : rdata0_r;
            end
        end else begin
            done0_nxt_s = 1'b0;
            done1_nxt_s = 1'b0;
        end
    end

    // State and registered-output update; PRESET aborts any transfer silently.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 1'b0;
            owner_r   <= 1'b0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {ADDR_W{1'b0}};
            pwdata_r  <= {DATA_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            done0_r   <= 1'b0;
            done1_r   <= 1'b0;
            rdata0_r  <= {DATA_W{1'b0}};
            rdata1_r  <= {DATA_W{1'b0}};
            err0_r    <= 1'b0;
            err1_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            owner_r   <= owner_nxt_s;
            psel_r    <= psel_nxt_s;
            penable_r <= penable_nxt_s;
            pwrite_r  <= pwrite_nxt_s;
            paddr_r   <= paddr_nxt_s;
            pwdata_r  <= pwdata_nxt_s;
            cnt_r     <= cnt_nxt_s;
            done0_r   <= done0_nxt_s;
            done1_r   <= done1_nxt_s;
            rdata0_r  <= rdata0_nxt_s;
            rdata1_r  <= rdata1_nxt_s;
            err0_r    <= err0_nxt_s;
            err1_r    <= err1_nxt_s;
        end
    end

    assign apb.PSELx   = psel_r;
    assign apb.PENABLE = penable_r;
    assign apb.PWRITE  = pwrite_r;
    assign apb.PADDR   = paddr_r;
    assign apb.PWDATA  = pwdata_r;
    assign done0       = done0_r;
    assign done1       = done1_r;
    assign rdata0      = rdata0_r;
    assign rdata1      = rdata1_r;
    assign err0        = err0_r;
    assign err1        = err1_r;
endmodule

// File: tb/tb_apb_rr_arbiter_master.sv
// Randomized scoreboard bench for apb_rr_arbiter_master with a responding APB slave model.
module tb_apb_rr_arbiter_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
    typedef struct { int waits; bit slverr; logic [31:0] prdata; } resp_t;
    typedef struct {
        bit port; bit wr; logic [31:0] addr; logic [31:0] wdata;
        bit err; logic [31:0] rdata; int lat; int grant_at; int gap; bit abort;
    } exp_t;

    logic PCLK = 1'b0;
    logic PRESET;
    logic req0, wr0, req1, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;
    logic done0, done1, err0, err1;

    apb_rr_arbiter_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    apb_rr_arbiter_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
        .done0(done0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
        .done1(done1), .rdata1(rdata1), .err1(err1),
        .apb(bus)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t  exp_q[$];
    resp_t plan_q[$];
    cmd_t  c0_q[$], c1_q[$];
    resp_t rsp_q[$];
    bit          mon_en = 1'b0;
    logic [31:0] shown_rdata[2];
    bit          shown_err[2];
    bit          model_ptr = 1'b0;
    logic [31:0] model_rdata[2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.wr    = 1'($urandom_range(0, 1));
        c.addr  = 32'($urandom_range(0, 255)) << 2;
        c.wdata = $urandom;
        return c;
    endfunction

    function automatic resp_t rand_resp();
        resp_t r;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 5)      r.waits = $urandom_range(0, 3);
        else if (sel == 6) r.waits = TO - 1;
        else if (sel == 7) r.waits = TO;
        else if (sel == 8) r.waits = TO + 2;
        else               r.waits = 0;
        r.slverr = ($urandom_range(0, 3) == 0);
        r.prdata = $urandom;
        return r;
    endfunction

    // APB slave model: follows the planned response for each transfer in service order.
    bit    in_acc = 1'b0;
    resp_t cur;
    always @(negedge PCLK) begin
        if (bus.PSELx === 1'b1 && bus.PENABLE === 1'b1) begin
            if (!in_acc) begin
                in_acc = 1'b1;
                chk("slave_plan_avail", plan_q.size() > 0, 1);
                if (plan_q.size() > 0) cur = plan_q.pop_front();
                else begin cur.waits = 0; cur.slverr = 1'b0; cur.prdata = 32'h0; end
            end
            if (cur.waits == 0) begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = cur.prdata;
                bus.PSLVERR = cur.slverr;
            end else begin
                cur.waits   = cur.waits - 1;
                bus.PREADY  = 1'b0;
                bus.PRDATA  = $urandom;
                bus.PSLVERR = 1'($urandom_range(0, 1));
            end
        end else begin
            in_acc      = 1'b0;
            bus.PREADY  = 1'($urandom_range(0, 1));
            bus.PRDATA  = $urandom;
            bus.PSLVERR = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: checks bus phases, grant timing and completions against the scoreboard.
    bit psel_prev = 1'b0;
    int grant_cyc = 0;
    int last_done_cyc = 0;
    always @(negedge PCLK) begin : mon
        exp_t e;
        if (mon_en) begin
            chk("done_exclusive", done0 & done1, 0);
            if (bus.PSELx && !psel_prev) begin
                grant_cyc = cyc;
                chk("grant_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    chk("setup_penable", bus.PENABLE, 0);
                    if (e.grant_at >= 0) chk("grant_cycle", grant_cyc, e.grant_at);
                    else                 chk("grant_gap", grant_cyc - last_done_cyc, e.gap);
                end
            end
            if (bus.PSELx && exp_q.size() > 0) begin
                e = exp_q[0];
                chk("bus_cmd", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {e.wr, e.addr, e.wdata});
            end
            if (done0 || done1) begin
                chk("done_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("done_port", done1, e.port);
                    chk("done_not_aborted", e.abort, 0);
                    chk("done_latency", cyc - grant_cyc, e.lat);
                    chk("done_err", e.port ? err1 : err0, e.err);
                    chk("done_rdata", e.port ? rdata1 : rdata0, e.rdata);
                    shown_rdata[e.port] = e.rdata;
                    shown_err[e.port]   = e.err;
                end
                last_done_cyc = cyc;
            end
            chk("held_port0", {rdata0, err0}, {shown_rdata[0], shown_err[0]});
            chk("held_port1", {rdata1, err1}, {shown_rdata[1], shown_err[1]});
        end
        psel_prev = bus.PSELx;
    end

    task automatic present(input bit p, input cmd_t c);
        if (p) begin wr1 = c.wr; addr1 = c.addr; wdata1 = c.wdata; end
        else   begin wr0 = c.wr; addr0 = c.addr; wdata0 = c.wdata; end
    endtask

    // One round: requests raised together, held until each port's commands are served.
    task automatic run_round(input bit use0, input bit use1, input int ncmd);
        bit    order[$];
        int    cnt[2];
        int    pres[2];
        int    idx[2];
        int    seen, c0, budget;
        bit    p, timed;
        cmd_t  cm;
        resp_t r;
        exp_t  e;
        cnt[0] = 0; cnt[1] = 0; idx[0] = 0; idx[1] = 0; pres[0] = 0; pres[1] = 0;
        for (int k = 0; k < ncmd; k++) begin
            p = (use0 && use1) ? model_ptr : use1;
            order.push_back(p);
            cnt[p]++;
            model_ptr = ~p;
        end
        while (c0_q.size() < cnt[0]) c0_q.push_back(rand_cmd());
        while (c1_q.size() < cnt[1]) c1_q.push_back(rand_cmd());
        while (rsp_q.size() < ncmd)  rsp_q.push_back(rand_resp());
        c0 = cyc;
        for (int k = 0; k < ncmd; k++) begin
            p = order[k];
            cm = p ? c1_q[idx[1]] : c0_q[idx[0]];
            idx[p]++;
            r = rsp_q[k];
            timed = (r.waits >= TO);
            if (!timed && !cm.wr) model_rdata[p] = r.prdata;
            e.port = p; e.wr = cm.wr; e.addr = cm.addr; e.wdata = cm.wdata;
            e.err = timed | r.slverr;
            e.rdata = model_rdata[p];
            e.lat = 2 + ((r.waits < TO - 1) ? r.waits : TO - 1);
            e.grant_at = (k == 0) ? c0 + 1 : -1;
            e.gap = (k > 0 && p == order[k-1]) ? 2 : 1;
            e.abort = 1'b0;
            exp_q.push_back(e);
            plan_q.push_back(r);
        end
        if (cnt[0] > 0) begin present(1'b0, c0_q[0]); req0 = 1'b1; end
        if (cnt[1] > 0) begin present(1'b1, c1_q[0]); req1 = 1'b1; end
        seen = 0;
        budget = ncmd * (TO + 8) + 10;
        for (int t = 0; t < budget && seen < ncmd; t++) begin
            @(negedge PCLK);
            if (ncmd == 1 && cyc == c0 + 1) begin
                present(order[0], rand_cmd());
                if ($urandom_range(0, 1) == 1) begin
                    if (order[0]) req1 = 1'b0; else req0 = 1'b0;
                end
            end
            if (done0 === 1'b1) begin
                seen++; pres[0]++;
                if (pres[0] < cnt[0]) present(1'b0, c0_q[pres[0]]); else req0 = 1'b0;
            end
            if (done1 === 1'b1) begin
                seen++; pres[1]++;
                if (pres[1] < cnt[1]) present(1'b1, c1_q[pres[1]]); else req1 = 1'b0;
            end
        end
        chk("round_complete", seen, ncmd);
        req0 = 1'b0; req1 = 1'b0;
        c0_q.delete(); c1_q.delete(); rsp_q.delete();
        repeat ($urandom_range(1, 3)) @(negedge PCLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t  cm;
        resp_t r;
        exp_t  e;
        PRESET = 1'b1;
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        req1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0;  wdata1 = 32'h0;
        shown_rdata[0] = 32'h0; shown_rdata[1] = 32'h0; shown_err[0] = 1'b0; shown_err[1] = 1'b0;
        model_rdata[0] = 32'h0; model_rdata[1] = 32'h0;

        // Reset held for two cycles with a pending request.
        repeat (2) begin
            @(negedge PCLK);
            chk("rst_psel", {bus.PSELx, bus.PENABLE}, 0);
        end
        chk("rst_bus", {bus.PWRITE, bus.PADDR, bus.PWDATA}, 0);
        chk("rst_port0", {done0, rdata0, err0}, 0);
        chk("rst_port1", {done1, rdata1, err1}, 0);
        PRESET = 1'b0; req0 = 1'b0;
        @(negedge PCLK);
        chk("post_rst_psel", bus.PSELx, 0);
        mon_en = 1'b1;

        // Write with zero wait states.
        c0_q.push_back('{wr: 1'b1, addr: 32'h4, wdata: 32'hA5A5A5A5});
        rsp_q.push_back('{waits: 0, slverr: 1'b0, prdata: 32'h0});
        run_round(1'b1, 1'b0, 1);
        // Read on port 1 with three wait states.
        c1_q.push_back('{wr: 1'b0, addr: 32'h8, wdata: 32'h0});
        rsp_q.push_back('{waits: 3, slverr: 1'b0, prdata: 32'h12345678});
        run_round(1'b0, 1'b1, 1);
        // Contention across four back-to-back commands.
        run_round(1'b1, 1'b1, 4);
        // Timeout on a read, then a slave error on a write.
        c0_q.push_back('{wr: 1'b0, addr: 32'h20, wdata: 32'h0});
        rsp_q.push_back('{waits: TO + 4, slverr: 1'b0, prdata: 32'hFFFF0000});
        run_round(1'b1, 1'b0, 1);
        c0_q.push_back('{wr: 1'b1, addr: 32'h24, wdata: 32'h5A5A5A5A});
        rsp_q.push_back('{waits: 1, slverr: 1'b1, prdata: 32'h0});
        run_round(1'b1, 1'b0, 1);
        // Timeout boundary: last wait cycle before expiry still completes normally.
        c1_q.push_back('{wr: 1'b0, addr: 32'h30, wdata: 32'h0});
        rsp_q.push_back('{waits: TO - 1, slverr: 1'b0, prdata: 32'hCAFEF00D});
        run_round(1'b0, 1'b1, 1);

        for (int i = 0; i < 40; i++) begin
            int u;
            u = $urandom_range(1, 3);
            run_round(u[0], u[1], $urandom_range(1, 4));
        end

        // Reset asserted during ACCESS: no completion, bus idles, pointer back to port 0.
        cm = rand_cmd();
        r = '{waits: TO + 5, slverr: 1'b0, prdata: 32'h0};
        e.port = 1'b1; e.wr = cm.wr; e.addr = cm.addr; e.wdata = cm.wdata;
        e.err = 1'b0; e.rdata = 32'h0; e.lat = 0; e.grant_at = cyc + 1; e.gap = 1; e.abort = 1'b1;
        exp_q.push_back(e);
        plan_q.push_back(r);
        present(1'b1, cm);
        req1 = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("abort_in_access", {bus.PSELx, bus.PENABLE}, 2'b11);
        mon_en = 1'b0;
        PRESET = 1'b1; req1 = 1'b0;
        shown_rdata[0] = 32'h0; shown_rdata[1] = 32'h0; shown_err[0] = 1'b0; shown_err[1] = 1'b0;
        model_rdata[0] = 32'h0; model_rdata[1] = 32'h0;
        model_ptr = 1'b0;
        @(negedge PCLK);
        chk("abort_bus_idle", {bus.PSELx, bus.PENABLE}, 0);
        chk("abort_no_done", {done0, done1}, 0);
        chk("abort_cleared", {rdata0, err0, rdata1, err1}, 0);
        PRESET = 1'b0;
        exp_q.delete();
        plan_q.delete();
        mon_en = 1'b1;
        repeat (2) @(negedge PCLK);
        run_round(1'b1, 1'b1, 2);

        repeat (5) @(negedge PCLK);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("plan_q_drained", plan_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
